transport_up_buf: RTL

- Parametrised successor of the PAICore upstream transport.
- Moves PAICore receive words into an AXI-Stream master through an internal FWFT buffer FIFO, so PAICore is decoupled from m_axis_tready backpressure.
- Detects end-of-frame from a programmable quiet window on done/busy.
- Appends an end-of-frame marker word with tlast, in order behind all data, and signals frame completion only after that marker has left the block.

---
 rtl/transport_up_buf_if.sv | 14 +
 rtl/transport_up_buf.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/transport_up_buf_if.sv
// AXI-Stream bundle carried by the upstream transport buffer.
// The master drives data/valid/last/hsked; the slave returns tready.
interface transport_up_buf_if #(
   parameter int DATA_W = 64
);
   logic [DATA_W-1:0] tdata;
   logic              tvalid;
   logic              tlast;
   logic              tready;
   logic              hsked;

   modport master (output tdata, output tvalid, output tlast, output hsked, input tready);
   modport slave  (input tdata, input tvalid, input tlast, input hsked, output tready);
endinterface

// File: rtl/transport_up_buf.sv
// PAICore upstream transport: FWFT buffer to AXI-Stream with quiet-window EOF marker.
// Optional macro TRANSPORT_UP_WCNT_EN adds a data-word count carried in the marker.
module transport_up_buf #(
   parameter int                DATA_W       = 64,
   parameter int                FIFO_DEPTH   = 16,
   parameter int                AFULL_MARGIN = 2,
   parameter int                DONE_CYCLES  = 61,
   parameter logic [DATA_W-1:0] EOF_WORD     = {DATA_W{1'b1}}
) (
   input  logic                        s_axis_aclk,
   input  logic                        s_axis_aresetn,
   output logic                        o_recv_available,
   input  logic                        i_recv_valid,
   input  logic [DATA_W-1:0]           i_recv_tdata,
   input  logic                        i_recv_done,
   input  logic                        i_recv_busy,
   transport_up_buf_if.master          m_axis,
   input  logic                        i_rx_rcving,
   output logic                        o_rx_done,
   output logic [$clog2(FIFO_DEPTH):0] o_fifo_level,
   output logic                        o_overflow
`ifdef TRANSPORT_UP_WCNT_EN
   ,
   output logic [31:0]                 o_word_cnt
`endif
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = AW + 1;
   localparam int CW = $clog2(DONE_CYCLES + 1);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_RECV  = 3'd1;
   localparam logic [2:0] S_EOF   = 3'd2;
   localparam logic [2:0] S_DRAIN = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   localparam logic [LW-1:0] DEPTH_L  = LW'(FIFO_DEPTH);
   localparam logic [LW-1:0] MARGIN_L = LW'(AFULL_MARGIN);
   localparam logic [LW-1:0] LVL_ONE  = LW'(1);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);
   localparam logic [CW-1:0] DONE_L   = CW'(DONE_CYCLES);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   logic [DATA_W:0]   r_mem [FIFO_DEPTH];
   logic [AW-1:0]     r_wr_ptr;
   logic [AW-1:0]     r_rd_ptr;
   logic [LW-1:0]     r_level;
   logic [2:0]        r_state;
   logic [2:0]        w_state_nxt;
   logic [CW-1:0]     r_done_cnt;
   logic              r_overflow;

   logic [DATA_W:0]   w_head;
   logic [DATA_W-1:0] w_marker;
   logic [DATA_W:0]   w_push_word;
   logic              w_valid;
   logic              w_hsked;
   logic              w_full;
   logic              w_room;
   logic              w_abort;
   logic              w_enter_recv;
   logic              w_data_push;
   logic              w_push_data_ok;
   logic              w_push_marker;
   logic              w_push;
   logic              w_qual;
   logic              w_fire;

   assign w_head         = r_mem[r_rd_ptr];
   assign w_valid        = (r_level != {LW{1'b0}});
   assign w_hsked        = w_valid & m_axis.tready;
   assign w_full         = (r_level == DEPTH_L);
   assign w_room         = ~w_full | w_hsked;
   assign w_abort        = ~i_rx_rcving & ((r_state == S_RECV) | (r_state == S_EOF) | (r_state == S_DRAIN));
   assign w_enter_recv   = (r_state == S_IDLE) & i_rx_rcving;
   assign w_data_push    = (r_state == S_RECV) & i_recv_valid;
   assign w_push_data_ok = w_data_push & w_room;
   assign w_push_marker  = (r_state == S_EOF) & w_room;
   assign w_push         = w_push_data_ok | w_push_marker;
   assign w_push_word    = w_push_marker ? {1'b1, w_marker} : {1'b0, i_recv_tdata};
   assign w_qual         = (r_state == S_RECV) & i_recv_done & ~i_recv_busy;
   assign w_fire         = (r_state == S_RECV) & (r_done_cnt == DONE_L);

   // Data outputs are masked while empty so the bus reads zero out of reset and after a flush
   assign m_axis.tvalid  = w_valid;
   assign m_axis.tdata   = w_valid ? w_head[DATA_W-1:0] : {DATA_W{1'b0}};
   assign m_axis.tlast   = w_valid & w_head[DATA_W];
   assign m_axis.hsked   = w_hsked;

   assign o_recv_available = (r_state == S_RECV) & ((DEPTH_L - r_level) > MARGIN_L);
   assign o_rx_done        = (r_state == S_DRAIN) & i_rx_rcving & w_hsked & w_head[DATA_W];
   assign o_fifo_level     = r_level;
   assign o_overflow       = r_overflow;

`ifdef TRANSPORT_UP_WCNT_EN
   logic [31:0] r_word_cnt;

   assign w_marker   = {EOF_WORD[DATA_W-1:32], r_word_cnt};
   assign o_word_cnt = r_word_cnt;

   // Accepted data-word counter, saturating
   always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
      if (!s_axis_aresetn) begin
         r_word_cnt <= 32'd0;
      end else if (w_enter_recv) begin
         r_word_cnt <= 32'd0;
      end else if (w_push_data_ok && (r_word_cnt != 32'hFFFF_FFFF)) begin
         r_word_cnt <= r_word_cnt + 32'd1;
      end else begin
         r_word_cnt <= r_word_cnt;
      end
   end
`else
   assign w_marker = EOF_WORD;
`endif

   // Session state transitions
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (i_rx_rcving) w_state_nxt = S_RECV;
            else             w_state_nxt = S_IDLE;
         end
         S_RECV: begin
            if (w_abort)     w_state_nxt = S_IDLE;
            else if (w_fire) w_state_nxt = S_EOF;
            else             w_state_nxt = S_RECV;
         end
         S_EOF: begin
            if (w_abort)     w_state_nxt = S_IDLE;
            else if (w_room) w_state_nxt = S_DRAIN;
            else             w_state_nxt = S_EOF;
         end
         S_DRAIN: begin
            if (w_abort)                       w_state_nxt = S_IDLE;
            else if (w_hsked && w_head[DATA_W]) w_state_nxt = S_DONE;
            else                               w_state_nxt = S_DRAIN;
         end
         S_DONE: begin
            if (!i_rx_rcving) w_state_nxt = S_IDLE;
            else              w_state_nxt = S_DONE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // State, FIFO pointers/level, done window and sticky overflow; abort flushes the FIFO
   always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
      if (!s_axis_aresetn) begin
         r_state    <= S_IDLE;
         r_wr_ptr   <= {AW{1'b0}};
         r_rd_ptr   <= {AW{1'b0}};
         r_level    <= {LW{1'b0}};
         r_done_cnt <= {CW{1'b0}};
         r_overflow <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (w_abort) begin
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
            r_level  <= {LW{1'b0}};
         end else begin
            r_wr_ptr <= w_push  ? r_wr_ptr + PTR_ONE : r_wr_ptr;
            r_rd_ptr <= w_hsked ? r_rd_ptr + PTR_ONE : r_rd_ptr;
            case ({w_push, w_hsked})
               2'b10:   r_level <= r_level + LVL_ONE;
               2'b01:   r_level <= r_level - LVL_ONE;
               default: r_level <= r_level;
            endcase
         end
         if (w_qual) r_done_cnt <= (r_done_cnt == DONE_L) ? r_done_cnt : r_done_cnt + CNT_ONE;
         else        r_done_cnt <= {CW{1'b0}};
         if (w_enter_recv)                  r_overflow <= 1'b0;
         else if (w_data_push && !w_room)   r_overflow <= 1'b1;
         else                               r_overflow <= r_overflow;
      end
   end

   // Buffer storage; contents are only observed through the level-qualified head
   always_ff @(posedge s_axis_aclk) begin
      if (w_push) r_mem[r_wr_ptr] <= w_push_word;
   end
endmodule
